// File: rtl/sram_stream_fifo.sv
// -----------------------------------------------------------------------------
// sram_stream_fifo
//
// Single-clock stream FIFO built on a 1-write/1-read synchronous SRAM with a
// one-cycle read latency. A two-entry output stage (head + skid register) is
// fed by a prefetcher so that the head word falls through to M_DATA and the
// read side can sustain one word per cycle despite the SRAM latency.
//
// Parameters
//   WIDTH      data word width in bits
//   DEPTH      capacity in words (power of two, >= 4); SRAM is DEPTH x WIDTH
//   AFULL_LVL  AFULL asserts when COUNT >= AFULL_LVL (1..DEPTH)
//
// Ports
//   CLK      clock for all logic and both SRAM ports
//   RSTN     asynchronous active-low reset
//   S_VALID  write side: word offered
//   S_READY  write side: FIFO can accept (registered)
//   S_DATA   write data
//   M_VALID  read side: head word available (registered)
//   M_READY  read side: consumer takes the head word
//   M_DATA   head word (registered, stable while M_VALID && !M_READY)
//   COUNT    words held, including words in the output stage
//   AFULL    COUNT >= AFULL_LVL (registered)
//   FLUSH    synchronous clear, present only with SRAM_FIFO_FLUSH_EN defined
//
// Optional feature macro: SRAM_FIFO_FLUSH_EN
//
// Handshake: a transfer happens on a rising CLK edge where valid && ready are
// both high. A producer holds valid and data until the transfer; ready may
// change freely and never depends combinationally on the other side.
// -----------------------------------------------------------------------------

// 1-write/1-read SRAM wrapper: write on wen, registered read when cen is low.
module sram_stream_fifo_sram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_wen,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_cen,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Contents are deliberately not reset, matching a real SRAM macro.
  always_ff @(posedge i_clk) begin
    if (i_wen) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (!i_cen) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

module sram_stream_fifo #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 1024,
  parameter int AFULL_LVL = DEPTH - 4
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic                       S_VALID,
  output logic                       S_READY,
  input  logic [WIDTH-1:0]           S_DATA,
  output logic                       M_VALID,
  input  logic                       M_READY,
  output logic [WIDTH-1:0]           M_DATA,
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
  output logic                       AFULL
`ifdef SRAM_FIFO_FLUSH_EN
  ,
  input  logic                       FLUSH
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

  // Storage pointers and bookkeeping
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_sram_cnt;   // words written to SRAM and not yet fetched
  logic             r_fetch_pend; // SRAM read issued last cycle, data on w_rdata
  logic [CW-1:0]    r_count;
  logic             r_s_ready;
  logic             r_afull;

  // Output stage: head drives M_DATA, skid catches a word arriving while
  // the head is occupied and not being popped.
  logic [WIDTH-1:0] r_head;
  logic             r_head_vld;
  logic [WIDTH-1:0] r_skid;
  logic             r_skid_vld;

  logic             w_flush;
  logic             w_push;
  logic             w_pop;
  logic             w_fetch;
  logic [1:0]       w_stage_after;
  logic [CW-1:0]    w_count_nxt;
  logic [CW-1:0]    w_sram_cnt_nxt;
  logic [WIDTH-1:0] w_rdata;
  logic             w_sram_cen;
  logic             w_sram_wen;

  logic [WIDTH-1:0] w_head_nxt;
  logic             w_head_vld_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             w_skid_vld_nxt;

`ifdef SRAM_FIFO_FLUSH_EN
  assign w_flush = FLUSH;
`else
  assign w_flush = 1'b0;
`endif

  // A flush cycle swallows any push and pop offered alongside it.
  assign w_push = S_VALID && r_s_ready && !w_flush;
  assign w_pop  = r_head_vld && M_READY && !w_flush;

  // Output-stage occupancy after this edge: current entries, plus the word
  // landing from the in-flight read, minus this edge's pop. The invariant
  // keeps the true value at or below 2, so 2-bit arithmetic is exact.
  assign w_stage_after = 2'({1'b0, r_head_vld}) + 2'({1'b0, r_skid_vld})
                       + 2'({1'b0, r_fetch_pend}) - 2'({1'b0, w_pop});

  // Fetch only words written on an earlier edge (r_sram_cnt excludes this
  // cycle's push), so a same-address read/write never happens, and only if
  // the fetched word will find a free slot when it lands.
  assign w_fetch = (r_sram_cnt != '0) && (w_stage_after != 2'd2) && !w_flush;

  assign w_sram_cen = !w_fetch;
  assign w_sram_wen = w_push;

  assign w_count_nxt    = r_count + CW'(w_push) - CW'(w_pop);
  assign w_sram_cnt_nxt = r_sram_cnt + CW'(w_push) - CW'(w_fetch);

  sram_stream_fifo_sram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .i_clk   (CLK),
    .i_wen   (w_sram_wen),
    .i_waddr (r_wptr),
    .i_wdata (S_DATA),
    .i_cen   (w_sram_cen),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  // Output-stage next state. The head only changes when it is empty or being
  // popped, which keeps M_DATA stable while M_VALID && !M_READY.
  always_comb begin
    w_head_nxt     = r_head;
    w_head_vld_nxt = r_head_vld;
    w_skid_nxt     = r_skid;
    w_skid_vld_nxt = r_skid_vld;
    if (w_pop) begin
      if (r_skid_vld) begin
        w_head_nxt     = r_skid;
        w_head_vld_nxt = 1'b1;
        w_skid_vld_nxt = r_fetch_pend;
        if (r_fetch_pend) begin
          w_skid_nxt = w_rdata;
        end
      end else begin
        w_head_vld_nxt = r_fetch_pend;
        if (r_fetch_pend) begin
          w_head_nxt = w_rdata;
        end
      end
    end else if (r_fetch_pend) begin
      if (!r_head_vld) begin
        w_head_nxt     = w_rdata;
        w_head_vld_nxt = 1'b1;
      end else begin
        w_skid_nxt     = w_rdata;
        w_skid_vld_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_sram_cnt   <= '0;
      r_fetch_pend <= 1'b0;
      r_count      <= '0;
      r_s_ready    <= 1'b1;
      r_afull      <= 1'b0;
      r_head       <= '0;
      r_head_vld   <= 1'b0;
      r_skid       <= '0;
      r_skid_vld   <= 1'b0;
`ifdef SRAM_FIFO_FLUSH_EN
    end else if (w_flush) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_sram_cnt   <= '0;
      r_fetch_pend <= 1'b0;
      r_count      <= '0;
      r_s_ready    <= 1'b1;
      r_afull      <= 1'b0;
      r_head       <= '0;
      r_head_vld   <= 1'b0;
      r_skid       <= '0;
      r_skid_vld   <= 1'b0;
`endif
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_fetch) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_sram_cnt   <= w_sram_cnt_nxt;
      r_fetch_pend <= w_fetch;
      r_count      <= w_count_nxt;
      // Registered from the next-state count: a pop at full does not open
      // the write side until the following cycle.
      r_s_ready    <= (w_count_nxt < DEPTH_C);
      r_afull      <= (w_count_nxt >= AFULL_C);
      r_head       <= w_head_nxt;
      r_head_vld   <= w_head_vld_nxt;
      r_skid       <= w_skid_nxt;
      r_skid_vld   <= w_skid_vld_nxt;
    end
  end

  assign S_READY = r_s_ready;
  assign M_VALID = r_head_vld;
  assign M_DATA  = r_head;
  assign COUNT   = r_count;
  assign AFULL   = r_afull;

endmodule

// File: tb/tb_sram_stream_fifo.sv
// -----------------------------------------------------------------------------
// tb_sram_stream_fifo
//
// Directed bench for sram_stream_fifo with DEPTH=8, AFULL_LVL=4. A small
// reference model (occupancy counter + expected-data queue) predicts COUNT,
// S_READY, AFULL and every popped word; directed steps add explicit checks for
// latency, fill/full behaviour, streaming throughput and mid-burst reset.
// -----------------------------------------------------------------------------
module tb_sram_stream_fifo;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int AL = 4;
  localparam int CW = $clog2(D + 1);

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          S_VALID = 1'b0;
  logic          S_READY;
  logic [W-1:0]  S_DATA = '0;
  logic          M_VALID;
  logic          M_READY = 1'b0;
  logic [W-1:0]  M_DATA;
  logic [CW-1:0] COUNT;
  logic          AFULL;
`ifdef SRAM_FIFO_FLUSH_EN
  logic          FLUSH = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;
  logic [W-1:0] exp_q[$];

  sram_stream_fifo #(
    .WIDTH     (W),
    .DEPTH     (D),
    .AFULL_LVL (AL)
  ) dut (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .S_VALID (S_VALID),
    .S_READY (S_READY),
    .S_DATA  (S_DATA),
    .M_VALID (M_VALID),
    .M_READY (M_READY),
    .M_DATA  (M_DATA),
    .COUNT   (COUNT),
    .AFULL   (AFULL)
`ifdef SRAM_FIFO_FLUSH_EN
    ,
    .FLUSH   (FLUSH)
`endif
  );

  // ---------------- clock / watchdog ----------------
  initial forever #5 CLK = ~CLK;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_cnt = 0;
  endtask

  // One clock cycle: called 1 time unit after an edge, drives inputs for the
  // next edge, predicts the transfer, then checks state 1 unit after the edge.
  task automatic cyc(input logic sv, input logic [W-1:0] sd, input logic mr,
                     output logic popped);
    logic         push;
    logic         pop;
    logic         hold;
    logic [W-1:0] held;
    S_VALID = sv;
    S_DATA  = sd;
    M_READY = mr;
    push = sv && (model_cnt < D);
    pop  = (M_VALID === 1'b1) && mr;
    hold = (M_VALID === 1'b1) && !mr;
    held = M_DATA;
    if (pop) begin
      check("pop_queue_nonempty", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("pop_data", 32'(M_DATA), 32'(exp_q.pop_front()));
    end
    @(posedge CLK);
    #1;
    if (push) exp_q.push_back(sd);
    model_cnt = model_cnt + int'(push) - int'(pop);
    popped = pop;
    check("count",   32'(COUNT),   32'(model_cnt));
    check("s_ready", 32'(S_READY), 32'(model_cnt < D));
    check("afull",   32'(AFULL),   32'(model_cnt >= AL));
    if (hold) begin
      check("hold_valid", 32'(M_VALID), 1);
      check("hold_data",  32'(M_DATA),  32'(held));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic p;
    logic sv;
    logic mr;
    int   sent;
    int   pops;
    int   first_pop;
    int   last_pop;
    int   max_cnt;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_count",   32'(COUNT),   0);
    check("rst_s_ready", 32'(S_READY), 1);
    check("rst_m_valid", 32'(M_VALID), 0);
    check("rst_m_data",  32'(M_DATA),  0);
    check("rst_afull",   32'(AFULL),   0);
    RSTN = 1'b1;
    model_reset();

    // Single push, two-edge latency to M_VALID
    cyc(1'b1, 16'h00A5, 1'b0, p);          // edge 1: push
    check("lat_valid_e1", 32'(M_VALID), 0);
    cyc(1'b0, 16'h0000, 1'b0, p);          // edge 2
    check("lat_valid_e2", 32'(M_VALID), 0);
    cyc(1'b0, 16'h0000, 1'b0, p);          // edge 3
    check("lat_valid_e3", 32'(M_VALID), 1);
    check("lat_data_e3",  32'(M_DATA),  32'h00A5);
    check("lat_count_e3", 32'(COUNT),   1);
    cyc(1'b0, 16'h0000, 1'b1, p);          // pop 0x00A5
    check("lat_popped", 32'(p), 1);
    M_READY = 1'b0;

    // Fill to full; AFULL asserts from COUNT=4
    for (int i = 0; i < D; i++) begin
      cyc(1'b1, W'(i), 1'b0, p);
      check("fill_afull", 32'(AFULL), 32'((i + 1) >= AL));
    end
    check("full_count",   32'(COUNT),   8);
    check("full_s_ready", 32'(S_READY), 0);
    cyc(1'b1, 16'h0009, 1'b0, p);          // held off
    cyc(1'b1, 16'h0009, 1'b0, p);
    check("full_hold_count", 32'(COUNT),   8);
    check("full_head_valid", 32'(M_VALID), 1);
    check("full_head_data",  32'(M_DATA),  0);

    // Pop at full with push offered: only the pop happens
    cyc(1'b1, 16'h0009, 1'b1, p);
    check("fullpop_popped",  32'(p),       1);
    check("fullpop_count",   32'(COUNT),   7);
    check("fullpop_s_ready", 32'(S_READY), 1);
    check("fullpop_head",    32'(M_DATA),  1);
    cyc(1'b1, 16'h0009, 1'b0, p);          // push of 0x0009 now accepted
    check("refill_count",   32'(COUNT),   8);
    check("refill_s_ready", 32'(S_READY), 0);

    // Drain: expect 1..7 then 9
    for (int c = 0; c < 40 && (model_cnt > 0); c++) cyc(1'b0, 16'h0000, 1'b1, p);
    check("drain_queue_empty", 32'(exp_q.size()), 0);
    check("drain_m_valid",     32'(M_VALID), 0);

    // Streaming: 100 words, both sides always willing. Push at edge k is
    // poppable at edge k+3, so steady-state occupancy is 3.
    sent = 0; pops = 0; first_pop = -1; last_pop = -1; max_cnt = 0;
    for (int c = 0; c < 300 && pops < 100; c++) begin
      sv = (sent < 100);
      if (sv && (model_cnt < D)) begin
        cyc(1'b1, W'(sent), 1'b1, p);
        sent++;
      end else begin
        cyc(1'b0, 16'h0000, 1'b1, p);
      end
      if (p) begin
        if (first_pop < 0) first_pop = c;
        last_pop = c;
        pops++;
      end
      if (int'(COUNT) > max_cnt) max_cnt = int'(COUNT);
    end
    check("stream_sent",      32'(sent), 100);
    check("stream_pops",      32'(pops), 100);
    check("stream_no_bubble", 32'(last_pop - first_pop), 99);
    check("stream_max_count", 32'(max_cnt <= 3), 1);
    check("stream_empty",     32'(COUNT), 0);

    // Random backpressure
    sent = 0;
    for (int c = 0; c < 20000 && (sent < 2000 || model_cnt > 0); c++) begin
      sv = (sent < 2000) && ($urandom_range(0, 1) == 1);
      mr = ($urandom_range(0, 1) == 1);
      if (sv && (model_cnt < D)) sent++;
      cyc(sv, W'($urandom_range(0, 65535)), mr, p);
    end
    check("rand_sent",        32'(sent), 2000);
    check("rand_queue_empty", 32'(exp_q.size()), 0);

    // Reset mid-burst with a fetch in flight
    for (int i = 0; i < 5; i++) cyc(1'b1, W'(16'h0050 + i), 1'b0, p);
    cyc(1'b0, 16'h0000, 1'b0, p);
    cyc(1'b0, 16'h0000, 1'b0, p);
    cyc(1'b1, 16'h0055, 1'b1, p);          // pop + push: refetch launched
    check("mid_count", 32'(COUNT), 5);
    S_VALID = 1'b0;
    M_READY = 1'b0;
    #1 RSTN = 1'b0;
    #1;
    check("arst_count",   32'(COUNT),   0);
    check("arst_m_valid", 32'(M_VALID), 0);
    check("arst_s_ready", 32'(S_READY), 1);
    check("arst_m_data",  32'(M_DATA),  0);
    model_reset();
    @(posedge CLK);
    #1 RSTN = 1'b1;
    @(posedge CLK);
    #1;
    check("post_rst_count",   32'(COUNT),   0);
    check("post_rst_m_valid", 32'(M_VALID), 0);
    check("post_rst_s_ready", 32'(S_READY), 1);
    cyc(1'b1, 16'h1234, 1'b0, p);
    cyc(1'b0, 16'h0000, 1'b0, p);
    cyc(1'b0, 16'h0000, 1'b0, p);
    check("post_rst_first_valid", 32'(M_VALID), 1);
    check("post_rst_first_data",  32'(M_DATA),  32'h1234);
    cyc(1'b0, 16'h0000, 1'b1, p);
    check("post_rst_popped", 32'(p), 1);
    cyc(1'b0, 16'h0000, 1'b0, p);
    check("post_rst_empty", 32'(M_VALID), 0);

`ifdef SRAM_FIFO_FLUSH_EN
    // Synchronous flush with push and pop offered in the same cycle
    for (int i = 0; i < 5; i++) cyc(1'b1, W'(16'h0070 + i), 1'b0, p);
    cyc(1'b0, 16'h0000, 1'b0, p);
    cyc(1'b1, 16'h0077, 1'b1, p);
    S_VALID = 1'b1;
    S_DATA  = 16'h0078;
    M_READY = 1'b1;
    FLUSH   = 1'b1;
    @(posedge CLK);
    #1;
    FLUSH   = 1'b0;
    S_VALID = 1'b0;
    M_READY = 1'b0;
    model_reset();
    check("flush_count",   32'(COUNT),   0);
    check("flush_m_valid", 32'(M_VALID), 0);
    check("flush_s_ready", 32'(S_READY), 1);
    check("flush_afull",   32'(AFULL),   0);
    cyc(1'b1, 16'h4321, 1'b0, p);
    cyc(1'b0, 16'h0000, 1'b0, p);
    cyc(1'b0, 16'h0000, 1'b0, p);
    check("flush_first_data", 32'(M_DATA), 32'h4321);
    cyc(1'b0, 16'h0000, 1'b1, p);
    check("flush_popped", 32'(p), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
